// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
package mips_pkg;
  localparam int REG_W     = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_GP   = 5'd28;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd29;

  typedef logic [REG_W-1:0] reg_word_t;
endpackage

// File: rtl/decoder5to32.sv
// 5-bit index to 32-bit one-hot decoder.
module decoder5to32
  import mips_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx_i,
  output logic [NUM_REGS-1:0]  onehot_o
);

  assign onehot_o = NUM_REGS'(1) << idx_i;

endmodule

// File: rtl/register_file.sv
// MIPS 32x32 register file, 1 sync write, 2 async reads.
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module register_file
  import mips_pkg::*;
#(
  parameter reg_word_t SP_INIT = 32'h0000_3FFC,
  parameter reg_word_t GP_INIT = 32'h0000_1800
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regWrite,
  input  logic [REG_IDX_W-1:0] writeReg,
  input  reg_word_t            writeData,
  input  logic [REG_IDX_W-1:0] readReg1,
  input  logic [REG_IDX_W-1:0] readReg2,
  output reg_word_t            readData1,
  output reg_word_t            readData2
);

  logic [NUM_REGS-1:0] we;
  reg_word_t           regs_q [1:NUM_REGS-1];
  reg_word_t           words  [0:NUM_REGS-1];

  decoder5to32 u_dec (
    .idx_i    (writeReg),
    .onehot_o (we)
  );

  // we[0] is never consulted, so $0 has no storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i == int'(REG_GP))
          regs_q[i] <= GP_INIT;
        else if (i == int'(REG_SP))
          regs_q[i] <= SP_INIT;
        else
          regs_q[i] <= '0;
      end
    end else if (regWrite) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we[i])
          regs_q[i] <= writeData;
      end
    end
  end

  always_comb begin
    words[0] = '0;
    for (int i = 1; i < NUM_REGS; i++)
      words[i] = regs_q[i];
  end

  always_comb begin
    readData1 = words[readReg1];
    readData2 = words[readReg2];
`ifdef REGFILE_BYPASS_EN
    if (regWrite && !reset && writeReg != REG_ZERO) begin
      if (readReg1 == writeReg)
        readData1 = writeData;
      if (readReg2 == writeReg)
        readData2 = writeData;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int compared = 0;
  int mismatched = 0;

  register_file dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1;
    regWrite = 1'b0;
    writeReg = 5'd0;
    writeData = 32'd0;
    readReg1 = 5'd29;
    readReg2 = 5'd28;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (readData1 !== 32'h0000_3FFC) begin
      mismatched++;
      $display("FAIL reset_sp got=%h exp=%h", readData1, 32'h3FFC);
    end
    compared++;
    if (readData2 !== 32'h0000_1800) begin
      mismatched++;
      $display("FAIL reset_gp got=%h exp=%h", readData2, 32'h1800);
    end
    readReg1 = 5'd5;
    #1;
    compared++;
    if (readData1 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_r5 got=%h exp=0", readData1);
    end
    for (int i = 0; i < 32; i++) begin
      readReg2 = 5'(i);
      exp = (i == 28) ? 32'h1800 : (i == 29) ? 32'h3FFC : 32'd0;
      #1;
      compared++;
      if (readData2 !== exp) begin
        mismatched++;
        $display("FAIL reset_sweep r%0d got=%h exp=%h", i, readData2, exp);
      end
    end
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    reset = 1'b0;
    regWrite = 1'b1;
    writeReg = 5'd8;
    writeData = 32'd546;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    readReg1 = 5'd8;
    readReg2 = 5'd9;
    #1;
    compared++;
    if (readData1 !== 32'd546) begin
      mismatched++;
      $display("FAIL basic_r8 got=%0d exp=546", readData1);
    end
    compared++;
    if (readData2 !== 32'd0) begin
      mismatched++;
      $display("FAIL basic_r9 got=%0d exp=0", readData2);
    end
  endtask

  task automatic test_zero_protect();
    @(negedge clk);
    regWrite = 1'b1;
    writeReg = 5'd0;
    writeData = 32'hDEAD_BEEF;
    readReg1 = 5'd0;
    #1;
    compared++;
    if (readData1 !== 32'd0) begin
      mismatched++;
      $display("FAIL zero_pre got=%h exp=0", readData1);
    end
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #1;
    compared++;
    if (readData1 !== 32'd0) begin
      mismatched++;
      $display("FAIL zero_post got=%h exp=0", readData1);
    end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    regWrite = 1'b0;
    writeReg = 5'd8;
    writeData = 32'd111;
    readReg1 = 5'd8;
    @(posedge clk);
    #1;
    compared++;
    if (readData1 !== 32'd546) begin
      mismatched++;
      $display("FAIL wdis_r8 got=%0d exp=546", readData1);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    writeReg = 5'd8;
    writeData = 32'd222;
    regWrite = 1'b1;
    #2;
    regWrite = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (readData1 !== 32'd546) begin
      mismatched++;
      $display("FAIL glitch_r8 got=%0d exp=546", readData1);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    regWrite = 1'b1;
    writeReg = 5'd8;
    writeData = 32'd777;
    readReg1 = 5'd8;
    readReg2 = 5'd8;
    #1;
`ifdef REGFILE_BYPASS_EN
    compared++;
    if (readData1 !== 32'd777) begin
      mismatched++;
      $display("FAIL same_pre1 got=%0d exp=777", readData1);
    end
    compared++;
    if (readData2 !== 32'd777) begin
      mismatched++;
      $display("FAIL same_pre2 got=%0d exp=777", readData2);
    end
`else
    compared++;
    if (readData1 !== 32'd546) begin
      mismatched++;
      $display("FAIL same_pre1 got=%0d exp=546", readData1);
    end
    compared++;
    if (readData2 !== 32'd546) begin
      mismatched++;
      $display("FAIL same_pre2 got=%0d exp=546", readData2);
    end
`endif
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #1;
    compared++;
    if (readData1 !== 32'd777) begin
      mismatched++;
      $display("FAIL same_post1 got=%0d exp=777", readData1);
    end
    compared++;
    if (readData2 !== 32'd777) begin
      mismatched++;
      $display("FAIL same_post2 got=%0d exp=777", readData2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [4:0]  idx  [4];
    vals = '{32'h1111_0001, 32'h2222_0002, 32'hA5A5_5A5A, 32'hFFFF_FFFF};
    idx  = '{5'd1, 5'd2, 5'd30, 5'd31};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      regWrite = 1'b1;
      writeReg = idx[k];
      writeData = vals[k];
      @(negedge clk);
    end
    regWrite = 1'b0;
    for (int k = 0; k < 4; k++) begin
      readReg1 = idx[k];
      readReg2 = idx[3-k];
      #1;
      compared++;
      if (readData1 !== vals[k]) begin
        mismatched++;
        $display("FAIL b2b_p1 r%0d got=%h exp=%h", idx[k], readData1, vals[k]);
      end
      compared++;
      if (readData2 !== vals[3-k]) begin
        mismatched++;
        $display("FAIL b2b_p2 r%0d got=%h exp=%h",
                 idx[3-k], readData2, vals[3-k]);
      end
    end
    readReg1 = 5'd8;
    #1;
    compared++;
    if (readData1 !== 32'd777) begin
      mismatched++;
      $display("FAIL b2b_r8 got=%0d exp=777", readData1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    regWrite = 1'b1;
    writeReg = 5'd8;
    writeData = 32'd546;
    @(negedge clk);
    regWrite = 1'b0;
    readReg1 = 5'd8;
    readReg2 = 5'd29;
    #1;
    compared++;
    if (readData1 !== 32'd546) begin
      mismatched++;
      $display("FAIL arst_pre got=%0d exp=546", readData1);
    end
    #1;
    reset = 1'b1;
    #1;
    compared++;
    if (readData1 !== 32'd0) begin
      mismatched++;
      $display("FAIL arst_r8 got=%0d exp=0", readData1);
    end
    compared++;
    if (readData2 !== 32'h3FFC) begin
      mismatched++;
      $display("FAIL arst_sp got=%h exp=3ffc", readData2);
    end
    @(negedge clk);
    regWrite = 1'b1;
    writeReg = 5'd8;
    writeData = 32'd999;
    #1;
    compared++;
    if (readData1 !== 32'd0) begin
      mismatched++;
      $display("FAIL arst_nobyp got=%0d exp=0", readData1);
    end
    @(posedge clk);
    #1;
    compared++;
    if (readData1 !== 32'd0) begin
      mismatched++;
      $display("FAIL arst_blocked got=%0d exp=0", readData1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #1;
    compared++;
    if (readData1 !== 32'd999) begin
      mismatched++;
      $display("FAIL arst_after got=%0d exp=999", readData1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_zero_protect();
    test_write_disable();
    test_glitch();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

MIPS general-purpose register file: 32 words of 32 bits, one synchronous write port and two asynchronous read ports. It is the storage stage that consumes the decode stage's register indices and write-back data. It produces the rs/rt operands for the ALU stage. Internally, a 5-to-32 write decoder drives one per-word write-enable line into each 32-bit storage word.

## Interface
Parameters:
- `SP_INIT`, default 32'h0000_3FFC: reset value of register 29 ($sp).
- `GP_INIT`, default 32'h0000_1800: reset value of register 28 ($gp).

Ports:
- `clk` input 1: single clock; all writes on rising edge.
- `reset` input 1: asynchronous, active-high; loads reset values immediately, independent of `clk`.
- `regWrite` input 1: write strobe from control.
- `writeReg` input 5: destination register index.
- `writeData` input 32: write-back value.
- `readReg1` input 5: rs index.
- `readReg2` input 5: rt index.
- `readData1` output 32: rs operand.
- `readData2` output 32: rt operand.

## Operation
- Storage: words 1..31, 32 bits each. Register 0 has no storage and reads as 32'h0 always.
- Reset, while `reset`=1:
  - word 28 = `GP_INIT`, word 29 = `SP_INIT`, all other words = 0.
  - Writes are blocked for as long as reset is held.
- Write decode: `decoder5to32` converts `writeReg` into a one-hot enable.
  - Word i captures `writeData` at rising `clk` when `regWrite`=1, enable[i]=1 and `reset`=0.
  - enable[0] is ignored, so writes to $0 are discarded.
- Read: `readDataN` = word[`readRegN`], combinational, with no clock involvement.
- Both read ports may address the same register; each returns the identical value.
- Read and write to different registers in the same cycle are independent.
- Read of the register being written in the same cycle: behaviour is set by the configuration macro (see Configuration).
- Width rules: no arithmetic. Indices are exactly 5 bits, so no out-of-range case exists.

## Timing
- Write latency: 1 cycle. A value written at edge N is visible on the read ports immediately after edge N.
- Read latency: 0 cycles, combinational from `readRegN` and storage.
- Reset assertion mid-cycle: outputs reflect reset values immediately, asynchronously, without waiting for `clk`.
- Reset deassertion coinciding with a rising `clk` while `regWrite`=1: that write is dropped. The first honoured write is at the next edge.
- `regWrite` toggling between edges has no effect; only the level sampled at the rising edge matters.
- Reset values of outputs:
  - `readDataN` = 0, except when `readRegN`=28 (`GP_INIT`) or `readRegN`=29 (`SP_INIT`).

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined:
  - When `regWrite`=1, `reset`=0, `writeReg`!=0 and `readRegN`==`writeReg`, `readDataN` returns `writeData` combinationally in the same cycle (write-through forwarding).
  - $0 is never bypassed.
- Undefined: `readDataN` returns the stored (old) value until the edge commits the write.

## Structure
- Shared package `mips_pkg`:
  - `REG_W`=32, `REG_IDX_W`=5, `NUM_REGS`=32.
  - Named indices `REG_ZERO`=0, `REG_GP`=28, `REG_SP`=29.
  - Typedef `reg_word_t` (32-bit).
- Sub-module: `decoder5to32` (5-bit index → 32-bit one-hot). It is instantiated once and is independently testable.
- The read muxes stay inline in `register_file`.

## Test plan
- Reset check: assert `reset`, set `readReg1`=29 and `readReg2`=28 → `readData1`=32'h3FFC, `readData2`=32'h1800. Then read index 5 → 0.
- Basic write/read: release reset and write 32'd546 to reg 8 with `regWrite`=1 for one edge. Then `readReg1`=8 → 546, and `readReg2`=9 → 0.
- $0 protection: write 32'hDEADBEEF to reg 0 → `readData1` with `readReg1`=0 stays 0, with and without `REGFILE_BYPASS_EN`.
- Write disable: `regWrite`=0 with `writeData`=32'd111 and `writeReg`=8 → reg 8 still 546 after the edge.
- Same-cycle read/write of reg 8 with 32'd777 before the edge:
  - bypass build → 777 before the edge;
  - non-bypass build → 546 before the edge and 777 after it.
- Async reset mid-operation: reg 8 = 546, assert `reset` midway between edges → `readData1` (reg 8) = 0 immediately. A `regWrite` edge during reset leaves it 0.
